// File: rtl/fpu_cmd_sequencer.sv
// ============================================================================
// fpu_cmd_sequencer
// ----------------------------------------------------------------------------
// Host-side controller for the byte-wide FPU register interface. One request
// (opcode + two 32-bit operands) produces nine register writes (A bytes at
// 0..3, B bytes at 4..7, opcode at 8). The sequencer then waits for
// fpu_cmd_end and reads the four result bytes at RES_BASE..RES_BASE+3. It
// acknowledges with fpu_end_ack and returns the 32-bit result. It is the only
// master of the fpu bus.
//
// Ports
//   clk, arst_n        clock, asynchronous active-low reset
//   start              request pulse, sampled only while idle
//   opcode/op_a/op_b   request payload, latched when start is accepted
//   busy               high from accepted start until done/err
//   done               1-cycle pulse, result valid
//   err                1-cycle pulse on fpu_cmd_end timeout
//   result             last completed result, held until the next done
//   fpu_addr           fpu register address
//   fpu_data_out       write data to the fpu
//   fpu_data_in        read data from the fpu
//   fpu_cs_n           chip select, active low
//   fpu_rd_n           read strobe, active low
//   fpu_wr_n           write strobe, active low
//   fpu_end_ack        end acknowledge to the fpu
//   fpu_cmd_end        fpu command complete
//   fpu_busy           fpu operation in progress
//
// All outputs come straight from flops.
// ============================================================================
module fpu_cmd_sequencer #(
  parameter int unsigned STROBE_CYC = 1,
  parameter int unsigned GAP_CYC    = 1,
  parameter logic [5:0]  RES_BASE   = 6'h09,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        start,
  input  logic [7:0]  opcode,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] result,
  output logic [5:0]  fpu_addr,
  output logic [7:0]  fpu_data_out,
  input  logic [7:0]  fpu_data_in,
  output logic        fpu_cs_n,
  output logic        fpu_rd_n,
  output logic        fpu_wr_n,
  output logic        fpu_end_ack,
  input  logic        fpu_cmd_end,
  input  logic        fpu_busy
);

  localparam int unsigned     TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [7:0]      STB_LAST = 8'(STROBE_CYC - 1);
  localparam logic [7:0]      GAP_LAST = 8'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_RDY = 3'd1,
    ST_WR_STB   = 3'd2,
    ST_WR_GAP   = 3'd3,
    ST_WAIT_END = 3'd4,
    ST_RD_STB   = 3'd5,
    ST_RD_GAP   = 3'd6,
    ST_ACK      = 3'd7
  } state_t;

  // Byte i of the write payload {opcode, op_b, op_a}.
  function automatic logic [7:0] wr_byte(input logic [71:0] w, input logic [3:0] i);
    logic [7:0] b;
    case (i)
      4'd0:    b = w[7:0];
      4'd1:    b = w[15:8];
      4'd2:    b = w[23:16];
      4'd3:    b = w[31:24];
      4'd4:    b = w[39:32];
      4'd5:    b = w[47:40];
      4'd6:    b = w[55:48];
      4'd7:    b = w[63:56];
      4'd8:    b = w[71:64];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  state_t        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [71:0]   wdata_q, wdata_d;
  logic [31:0]   shadow_q, shadow_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [31:0]   result_q, result_d;
  logic [5:0]    addr_q, addr_d;
  logic [7:0]    data_out_q, data_out_d;
  logic          cs_n_q, cs_n_d;
  logic          rd_n_q, rd_n_d;
  logic          wr_n_q, wr_n_d;
  logic          end_ack_q, end_ack_d;

  // Next-state, counters and status outputs; bus outputs follow from the next state.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    wdata_d    = wdata_q;
    shadow_d   = shadow_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    result_d   = result_q;
    end_ack_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // done_q high means this is the completion cycle; start is not taken then.
        if (start && !done_q) begin
          wdata_d = {opcode, op_b, op_a};
          busy_d  = 1'b1;
          state_d = ST_WAIT_RDY;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WAIT_RDY: begin
        if (fpu_busy || fpu_cmd_end) begin
          state_d = ST_WAIT_RDY;
        end else begin
          idx_d   = 4'd0;
          cnt_d   = 8'd0;
          state_d = ST_WR_STB;
        end
      end

      ST_WR_STB: begin
        if (cnt_q == STB_LAST) begin
          cnt_d   = 8'd0;
          state_d = ST_WR_GAP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ST_WR_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = 8'd0;
          if (idx_q == 4'd8) begin
            tmo_d   = '0;
            state_d = ST_WAIT_END;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = ST_WR_STB;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ST_WAIT_END: begin
        if (fpu_cmd_end) begin
          idx_d   = 4'd0;
          cnt_d   = 8'd0;
          state_d = ST_RD_STB;
        end else if (tmo_q == TMO_LAST) begin
          // Abort: pulse err and end_ack together, result untouched.
          err_d     = 1'b1;
          end_ack_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      ST_RD_STB: begin
        if (cnt_q == STB_LAST) begin
          // Sample on the last strobe cycle so the fpu has the full strobe to drive.
          shadow_d[{idx_q[1:0], 3'b000} +: 8] = fpu_data_in;
          cnt_d   = 8'd0;
          state_d = ST_RD_GAP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ST_RD_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = 8'd0;
          if (idx_q == 4'd3) begin
            end_ack_d = 1'b1;
            state_d   = ST_ACK;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = ST_RD_STB;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ST_ACK: begin
        if (!fpu_cmd_end) begin
          result_d = shadow_q;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = ST_IDLE;
        end else begin
          end_ack_d = 1'b1;
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bus strobes, address and write data derived from the next state.
  // addr/data only change on entry to a strobe, so they hold through the gap.
  always_comb begin
    cs_n_d     = 1'b1;
    rd_n_d     = 1'b1;
    wr_n_d     = 1'b1;
    addr_d     = addr_q;
    data_out_d = data_out_q;
    case (state_d)
      ST_WR_STB: begin
        cs_n_d     = 1'b0;
        wr_n_d     = 1'b0;
        addr_d     = {2'b00, idx_d};
        data_out_d = wr_byte(wdata_d, idx_d);
      end
      ST_WR_GAP: begin
        addr_d     = {2'b00, idx_d};
        data_out_d = wr_byte(wdata_d, idx_d);
      end
      ST_RD_STB: begin
        cs_n_d = 1'b0;
        rd_n_d = 1'b0;
        addr_d = RES_BASE + {2'b00, idx_d};
      end
      ST_RD_GAP: begin
        addr_d = RES_BASE + {2'b00, idx_d};
      end
      default: begin
        addr_d = addr_q;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction immediately.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= 4'd0;
      cnt_q      <= 8'd0;
      tmo_q      <= '0;
      wdata_q    <= 72'd0;
      shadow_q   <= 32'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      result_q   <= 32'd0;
      addr_q     <= 6'd0;
      data_out_q <= 8'd0;
      cs_n_q     <= 1'b1;
      rd_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      end_ack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      wdata_q    <= wdata_d;
      shadow_q   <= shadow_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      result_q   <= result_d;
      addr_q     <= addr_d;
      data_out_q <= data_out_d;
      cs_n_q     <= cs_n_d;
      rd_n_q     <= rd_n_d;
      wr_n_q     <= wr_n_d;
      end_ack_q  <= end_ack_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign result       = result_q;
  assign fpu_addr     = addr_q;
  assign fpu_data_out = data_out_q;
  assign fpu_cs_n     = cs_n_q;
  assign fpu_rd_n     = rd_n_q;
  assign fpu_wr_n     = wr_n_q;
  assign fpu_end_ack  = end_ack_q;

endmodule

// File: tb/tb_fpu_cmd_sequencer.sv
// ============================================================================
// tb_fpu_cmd_sequencer
// Bench for fpu_cmd_sequencer with a small behavioural fpu model. Each request
// pushes its expected bus accesses and its expected completion onto queues.
// A negedge monitor pops and compares them as the DUT produces them.
// ============================================================================
module tb_fpu_cmd_sequencer;

  localparam int         TMO    = 64;
  localparam logic [7:0] OP_MUL = 8'h03;

  typedef struct packed {
    logic       rd;
    logic [5:0] addr;
    logic [7:0] data;
  } acc_t;

  typedef struct packed {
    logic        is_err;
    logic [31:0] res;
  } res_t;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  opcode = 8'h00;
  logic [31:0] op_a = 32'h0;
  logic [31:0] op_b = 32'h0;
  logic        busy, done, err;
  logic [31:0] result;
  logic [5:0]  fpu_addr;
  logic [7:0]  fpu_data_out, fpu_data_in;
  logic        fpu_cs_n, fpu_rd_n, fpu_wr_n, fpu_end_ack;
  logic        fpu_cmd_end, fpu_busy;

  int n_chk  = 0;
  int n_fail = 0;

  acc_t exp_bus[$];
  res_t exp_res[$];
  logic [31:0] last_res = 32'h0;
  int n_exp = 0;

  fpu_cmd_sequencer #(
    .STROBE_CYC(1), .GAP_CYC(1), .RES_BASE(6'h09), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .arst_n(arst_n), .start(start), .opcode(opcode),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .err(err),
    .result(result), .fpu_addr(fpu_addr), .fpu_data_out(fpu_data_out),
    .fpu_data_in(fpu_data_in), .fpu_cs_n(fpu_cs_n), .fpu_rd_n(fpu_rd_n),
    .fpu_wr_n(fpu_wr_n), .fpu_end_ack(fpu_end_ack),
    .fpu_cmd_end(fpu_cmd_end), .fpu_busy(fpu_busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  // Reference fpu arithmetic: one known multiply vector, otherwise a simple mix.
  function automatic logic [31:0] fpu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [7:0] op);
    if (a == 32'h43e0d666 && b == 32'h43a6ffdf && op == OP_MUL) return 32'h4812abc0;
    else return (a + b) ^ {op, op, op, op};
  endfunction

  // ---------------- fpu model ----------------
  logic [7:0]  regs [0:8];
  logic [31:0] res_reg;
  logic        computing;
  int          cdelay;
  int          ack_cnt;
  bit          never_end  = 1'b0;
  bit          force_busy = 1'b0;
  int          hold_cyc   = 1;

  assign fpu_busy = force_busy | computing;

  function automatic logic [7:0] rd_byte(input logic [31:0] r, input logic [5:0] a);
    case (a)
      6'h09:   return r[7:0];
      6'h0A:   return r[15:8];
      6'h0B:   return r[23:16];
      6'h0C:   return r[31:24];
      default: return 8'h5A;
    endcase
  endfunction

  // Result bytes only appear while the read strobe is active; garbage otherwise.
  assign fpu_data_in = (!fpu_cs_n && !fpu_rd_n) ? rd_byte(res_reg, fpu_addr) : 8'h5A;

  // fpu register file, compute delay and cmd_end/end_ack handshake.
  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      computing   <= 1'b0;
      cdelay      <= 0;
      fpu_cmd_end <= 1'b0;
      ack_cnt     <= 0;
      res_reg     <= 32'h0;
    end else begin
      if (!fpu_cs_n && !fpu_wr_n && fpu_addr <= 6'd8) regs[fpu_addr[3:0]] <= fpu_data_out;
      if (!fpu_cs_n && !fpu_wr_n && fpu_addr == 6'd8) begin
        computing <= 1'b1;
        cdelay    <= 3;
      end else if (computing) begin
        if (cdelay == 0) begin
          computing <= 1'b0;
          res_reg   <= fpu_model({regs[3], regs[2], regs[1], regs[0]},
                                 {regs[7], regs[6], regs[5], regs[4]}, regs[8]);
          if (!never_end) fpu_cmd_end <= 1'b1;
        end else begin
          cdelay <= cdelay - 1;
        end
      end
      if (fpu_end_ack && fpu_cmd_end) begin
        if (ack_cnt + 1 >= hold_cyc) begin
          fpu_cmd_end <= 1'b0;
          ack_cnt     <= 0;
        end else begin
          ack_cnt <= ack_cnt + 1;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  int         cyc = 0;
  bit         prev_cs = 1'b1;
  logic [5:0] last_addr = 6'h0;
  logic [7:0] last_data = 8'h0;
  int         wr8_cyc = 0;
  int         fin_cyc = 0;
  int         n_done_seen = 0;
  int         ack_hi = 0;
  int         ack_ovl = 0;

  // Bus access and completion checks against the scoreboard queues.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (start) begin
      ack_hi  <= 0;
      ack_ovl <= 0;
    end else begin
      if (fpu_end_ack) ack_hi <= ack_hi + 1;
      if (fpu_end_ack && fpu_cmd_end) ack_ovl <= ack_ovl + 1;
    end

    if (!fpu_cs_n && prev_cs) begin
      check_eq("strobe_exclusive", 32'(fpu_rd_n ^ fpu_wr_n), 32'd1);
      if (exp_bus.size() == 0) begin
        check_eq("unexpected_access", 32'(exp_bus.size()), 32'd1);
      end else begin
        check_eq("acc_kind", 32'(!fpu_rd_n), 32'(exp_bus[0].rd));
        check_eq("acc_addr", 32'(fpu_addr), 32'(exp_bus[0].addr));
        if (!exp_bus[0].rd) check_eq("wr_data", 32'(fpu_data_out), 32'(exp_bus[0].data));
        void'(exp_bus.pop_front());
      end
      if (!fpu_wr_n && fpu_addr == 6'd8) wr8_cyc <= cyc;
      last_addr <= fpu_addr;
      last_data <= fpu_data_out;
    end
    if (fpu_cs_n && !prev_cs && arst_n) begin
      check_eq("addr_hold_gap", 32'(fpu_addr), 32'(last_addr));
      check_eq("data_hold_gap", 32'(fpu_data_out), 32'(last_data));
    end
    prev_cs <= fpu_cs_n;

    if (done || err) begin
      fin_cyc     <= cyc;
      n_done_seen <= n_done_seen + 1;
      check_eq("busy_low_at_end", 32'(busy), 32'd0);
      check_eq("done_err_exclusive", 32'(done & err), 32'd0);
      if (exp_res.size() == 0) begin
        check_eq("unexpected_completion", 32'(exp_res.size()), 32'd1);
      end else begin
        check_eq("completion_kind", 32'(err), 32'(exp_res[0].is_err));
        check_eq("result", result, exp_res[0].res);
        void'(exp_res.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_start(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit ends);
    logic [71:0] wb;
    logic [31:0] r;
    wb = {op, b, a};
    @(posedge clk); #1;
    opcode = op; op_a = a; op_b = b; start = 1'b1;
    for (int i = 0; i < 9; i++) exp_bus.push_back({1'b0, 6'(i), wb[8*i +: 8]});
    if (ends) begin
      for (int i = 0; i < 4; i++) exp_bus.push_back({1'b1, 6'h09 + 6'(i), 8'h00});
      r = fpu_model(a, b, op);
      exp_res.push_back({1'b0, r});
      last_res = r;
    end else begin
      exp_res.push_back({1'b1, last_res});
    end
    n_exp++;
    @(posedge clk); #1;
    start = 1'b0;
    opcode = 8'($urandom); op_a = $urandom; op_b = $urandom;
  endtask

  // Returns at the negedge where done or err is seen.
  task automatic wait_end(input int max);
    bit hit = 1'b0;
    for (int k = 0; k < max; k++) begin
      @(negedge clk);
      if (done || err) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) check_eq("wait_completion_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    bit hit;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_cs_n", 32'(fpu_cs_n), 32'd1);
    check_eq("rst_rd_n", 32'(fpu_rd_n), 32'd1);
    check_eq("rst_wr_n", 32'(fpu_wr_n), 32'd1);
    check_eq("rst_end_ack", 32'(fpu_end_ack), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done_err", 32'({done, err}), 32'd0);
    check_eq("rst_result", result, 32'h0);
    check_eq("rst_addr_data", 32'({fpu_addr, fpu_data_out}), 32'd0);
    arst_n = 1'b1;

    // Known multiply vector
    do_start(OP_MUL, 32'h43e0d666, 32'h43a6ffdf, 1'b1);
    wait_end(200);
    @(negedge clk);
    check_eq("done_one_cycle", 32'(done), 32'd0);
    check_eq("end_ack_cycles_default", 32'(ack_hi), 32'd2);

    // Several random requests
    for (int t = 0; t < 3; t++) begin
      do_start(8'($urandom), $urandom, $urandom, 1'b1);
      wait_end(200);
    end

    // start during WR_GAP is ignored
    do_start(8'h11, 32'h12345678, 32'h9abcdef0, 1'b1);
    hit = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (!fpu_cs_n && !fpu_wr_n) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) check_eq("wr_strobe_seen", 32'd0, 32'd1);
    @(negedge clk);
    check_eq("in_wr_gap", 32'(fpu_cs_n), 32'd1);
    start = 1'b1; op_a = 32'hdeadbeef; op_b = 32'hcafef00d; opcode = 8'h22;
    @(posedge clk); #1;
    start = 1'b0;
    wait_end(200);

    // start pulsed in the done cycle is ignored
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check_eq("start_in_done_cycle_ignored", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);

    // fpu_busy held: no access until it drops
    force_busy = 1'b1;
    do_start(8'h05, 32'h3f800000, 32'h40000000, 1'b1);
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (!fpu_cs_n) cnt++;
    end
    check_eq("no_access_while_fpu_busy", 32'(cnt), 32'd0);
    check_eq("busy_while_waiting", 32'(busy), 32'd1);
    force_busy = 1'b0;
    wait_end(200);

    // Timeout abort
    never_end = 1'b1;
    do_start(8'h07, 32'h00000001, 32'h00000002, 1'b0);
    wait_end(300);
    @(negedge clk);
    check_eq("timeout_cycles", 32'(fin_cyc - wr8_cyc), 32'd66);
    check_eq("err_one_cycle", 32'(err), 32'd0);
    check_eq("err_end_ack_pulse", 32'(ack_hi), 32'd1);
    check_eq("bus_idle_after_err", 32'({fpu_cs_n, fpu_rd_n, fpu_wr_n}), 32'd7);
    never_end = 1'b0;

    // cmd_end held 5 cycles after end_ack
    hold_cyc = 5;
    do_start(8'h09, 32'h0badf00d, 32'h00c0ffee, 1'b1);
    wait_end(200);
    @(negedge clk);
    check_eq("cmd_end_overlap", 32'(ack_ovl), 32'd5);
    check_eq("end_ack_hold_cycles", 32'(ack_hi), 32'd6);
    hold_cyc = 1;

    // Reset during a read strobe
    do_start(8'h0a, 32'h11111111, 32'h22222222, 1'b1);
    hit = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!fpu_rd_n) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) check_eq("rd_strobe_seen", 32'd0, 32'd1);
    arst_n = 1'b0;
    #1;
    check_eq("mid_rst_strobes", 32'({fpu_cs_n, fpu_rd_n, fpu_wr_n}), 32'd7);
    check_eq("mid_rst_end_ack", 32'(fpu_end_ack), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_result", result, 32'h0);
    exp_bus.delete();
    exp_res.delete();
    n_exp--;
    last_res = 32'h0;
    @(posedge clk);
    @(posedge clk); #1;
    arst_n = 1'b1;

    // Normal run after reset
    do_start(8'h0c, 32'h41200000, 32'hc1a00000, 1'b1);
    wait_end(200);

    repeat (4) @(negedge clk);
    check_eq("completions", 32'(n_done_seen), 32'(n_exp));
    check_eq("scoreboard_empty", 32'(exp_bus.size() + exp_res.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
